sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO for NoC router input/output buffering and for same-domain links between router stages.
- Generalises the 64-bit x 32-slot dual-clock FIFO: data width and depth are parameters.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
- DATA_WIDTH, 64, payload width in bits.
- ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 32 slots).
- AFULL_THRESH, 28, walmost_full asserts when count >= AFULL_THRESH. Legal range 1..DEPTH.
- AEMPTY_THRESH, 4, ralmost_empty asserts when count <= AEMPTY_THRESH. Legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- wdata  in  DATA_WIDTH  Write data.
- winc  in  1  Write request.
- wfull  out  1  FIFO full.
- walmost_full  out  1  count >= AFULL_THRESH.
- rinc  in  1  Read request.
- rdata  out  DATA_WIDTH  Read data.
- rempty  out  1  FIFO empty.
- ralmost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  Current occupancy, 0..DEPTH.
- overflow  out  1  Sticky: a write was attempted while full.
- underflow  out  1  Sticky: a read was attempted while empty.
- clr_err  in  1  Synchronous clear of overflow and underflow.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array. The array is not reset.
- Pointers:
  - wptr and rptr are binary, ADDR_WIDTH+1 bits wide. The MSB is the wrap bit.
  - Write address = wptr[ADDR_WIDTH-1:0]; read address = rptr[ADDR_WIDTH-1:0].
  - Both pointers wrap naturally modulo 2*DEPTH.
- Flags and count:
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - rempty = (wptr == rptr).
  - wfull = (MSBs differ) AND (lower bits equal).
  - wfull, rempty, walmost_full, ralmost_empty and count are combinational decodes of the registered pointers. They change only after a clock edge and are glitch-free relative to winc/rinc.
- Acceptance:
  - Write accepted iff winc && !wfull. On acceptance, mem[waddr] <= wdata and wptr increments by 1.
  - Read accepted iff rinc && !rempty. On acceptance, rptr increments by 1.
  - Acceptance is evaluated on the flags present at the start of the cycle.
- Simultaneous read and write:
  - Not full and not empty: both accepted; count unchanged.
  - Full: read accepted, write rejected, overflow set. Count goes DEPTH -> DEPTH-1.
  - Empty: write accepted, read rejected, underflow set. Count goes 0 -> 1.
- Read data, FWFT=0:
  - rdata is a register, loaded with mem[raddr] on an accepted read, so data appears 1 cycle after rinc.
  - rdata holds its value otherwise, including on a rejected read.
- Read data, FWFT=1:
  - rdata = mem[raddr] combinationally, so the head word is visible whenever !rempty. rinc acts as a pop.
  - rdata is don't-care while rempty=1.
  - A word written into an empty FIFO becomes visible on rdata in the cycle after the write edge.
- Error flags:
  - overflow is set on winc && wfull; underflow is set on rinc && rempty.
  - Both are cleared by clr_err. If an error event and clr_err occur in the same cycle, the set wins.
  - Rejected operations change no other state.
- Reset (any time, including mid-transfer), asynchronously:
  - wptr = rptr = 0, so rempty=1, wfull=0, count=0.
  - walmost_full = 0; ralmost_empty = 1 (for AEMPTY_THRESH >= 0).
  - overflow = underflow = 0; rdata register = 0 (FWFT=0).
  - Stored contents are lost logically. The first write after reset deasserts rempty at the next edge.
- Latency: write to rempty deassert = 1 cycle. Read to wfull deassert = 1 cycle.

Test Plan:
- Reset, then write 32 words 0x0..0x1F (default params) -> count steps 1..32. walmost_full asserts after the 28th write. wfull=1 after the 32nd. ralmost_empty deasserts after the 5th write.
- From full, assert winc with 0xDEAD for 1 cycle -> write rejected, overflow=1, count stays 32. Then pulse clr_err -> overflow=0.
- Read 32 words with FWFT=0 -> rdata sequence 0x0..0x1F, each 1 cycle after rinc. rempty=1 after the last read. An extra rinc sets underflow=1 and rdata holds 0x1F.
- Fill to 16, then 100 cycles of simultaneous winc+rinc with incrementing data -> count constant at 16, data in order, pointers wrap cleanly past 2*DEPTH. Repeat at full (count 32 -> 31, overflow=1) and at empty (count 0 -> 1, underflow=1).
- FWFT=1 build: write 0xA5 into empty -> rdata=0xA5 next cycle with no rinc. rinc pops it and rempty=1 the next cycle.
- Assert rst asynchronously mid-burst at count=10 -> immediately count=0, rempty=1, flags cleared. The next write/read pair returns the newly written value.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock parametrised FIFO with occupancy count,
//               almost-full/almost-empty thresholds, sticky overflow and
//               underflow flags and a selectable registered / first-word-
//               fall-through read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 5,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  winc,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int                c_DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_AFULL  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AEMPTY = AEMPTY_THRESH[ADDR_WIDTH:0];

    // Storage is deliberately left without reset; pointers define validity.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // Binary pointers with one extra wrap bit to tell full from empty.
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wacc;
    logic                  w_racc;

    assign w_waddr = r_wptr[ADDR_WIDTH-1:0];
    assign w_raddr = r_rptr[ADDR_WIDTH-1:0];

    // All status outputs decode only registered pointers, so they move only
    // on clock edges and never follow winc/rinc combinationally.
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                     (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);

    // Acceptance uses the flags as they stood at the start of the cycle.
    assign w_wacc = winc && !w_full;
    assign w_racc = rinc && !w_empty;

    assign count         = w_count;
    assign rempty        = w_empty;
    assign wfull         = w_full;
    assign walmost_full  = (w_count >= c_AFULL);
    assign ralmost_empty = (w_count <= c_AEMPTY);
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

    // Write port: store the accepted word at the write address.
    always_ff @(posedge clk) begin
        if (w_wacc) begin
            r_mem[w_waddr] <= wdata;
        end
    end

    // Pointer advance on accepted operations; wraps naturally at 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wacc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_racc) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Sticky error flags: a new error event takes priority over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rinc && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; meaningless while empty.
            assign rdata = r_mem[w_raddr];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rdata;

            // Registered read: load on an accepted read, hold otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_racc) begin
                    r_rdata <= r_mem[w_raddr];
                end
            end

            assign rdata = r_rdata;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param. Drives identical
//               stimulus into a registered-read and an FWFT instance and
//               compares both against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_DW     = 64;
    localparam int c_AW     = 5;
    localparam int c_DEPTH  = 32;
    localparam int c_AFULL  = 28;
    localparam int c_AEMPTY = 4;

    logic              clk;
    logic              rst;
    logic [c_DW-1:0]   wdata;
    logic              winc;
    logic              rinc;
    logic              clr_err;

    logic              wfull0, wafull0, rempty0, raempty0, ovf0, unf0;
    logic [c_DW-1:0]   rdata0;
    logic [c_AW:0]     count0;
    logic              wfull1, wafull1, rempty1, raempty1, ovf1, unf1;
    logic [c_DW-1:0]   rdata1;
    logic [c_AW:0]     count1;

    int                n_checks;
    int                n_fail;

    // Reference model: plain queue of stored words plus sticky flags.
    logic [c_DW-1:0]   m_q [$];
    logic [c_DW-1:0]   m_rdata;
    logic              m_ovf;
    logic              m_unf;

    sync_fifo_param #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .AFULL_THRESH(c_AFULL),
        .AEMPTY_THRESH(c_AEMPTY), .FWFT(0)
    ) u_dut_reg (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull0),
        .walmost_full(wafull0), .rinc(rinc), .rdata(rdata0), .rempty(rempty0),
        .ralmost_empty(raempty0), .count(count0), .overflow(ovf0),
        .underflow(unf0), .clr_err(clr_err)
    );

    sync_fifo_param #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .AFULL_THRESH(c_AFULL),
        .AEMPTY_THRESH(c_AEMPTY), .FWFT(1)
    ) u_dut_fwft (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull1),
        .walmost_full(wafull1), .rinc(rinc), .rdata(rdata1), .rempty(rempty1),
        .ralmost_empty(raempty1), .count(count1), .overflow(ovf1),
        .underflow(unf1), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        check("count",        64'(count0),   64'(sz));
        check("rempty",       64'(rempty0),  64'(sz == 0));
        check("wfull",        64'(wfull0),   64'(sz == c_DEPTH));
        check("walmost_full", 64'(wafull0),  64'(sz >= c_AFULL));
        check("ralmost_empty",64'(raempty0), 64'(sz <= c_AEMPTY));
        check("overflow",     64'(ovf0),     64'(m_ovf));
        check("underflow",    64'(unf0),     64'(m_unf));
        check("rdata_reg",    rdata0,        m_rdata);
        check("count_fwft",   64'(count1),   64'(sz));
        check("rempty_fwft",  64'(rempty1),  64'(sz == 0));
        check("wfull_fwft",   64'(wfull1),   64'(sz == c_DEPTH));
        check("afull_fwft",   64'(wafull1),  64'(sz >= c_AFULL));
        check("aempty_fwft",  64'(raempty1), 64'(sz <= c_AEMPTY));
        check("ovf_fwft",     64'(ovf1),     64'(m_ovf));
        check("unf_fwft",     64'(unf1),     64'(m_unf));
        if (sz > 0) begin
            check("rdata_fwft", rdata1, m_q[0]);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rdata = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock cycle of stimulus; model follows the FIFO rules at the edge.
    task automatic step(input logic w, input logic [63:0] d, input logic r, input logic c);
        bit was_full;
        bit was_empty;
        winc = w; wdata = d; rinc = r; clr_err = c;
        @(posedge clk);
        was_full  = (m_q.size() == c_DEPTH);
        was_empty = (m_q.size() == 0);
        if (r && !was_empty) m_rdata = m_q.pop_front();
        if (w && !was_full)  m_q.push_back(d);
        if (w && was_full)   m_ovf = 1'b1;
        else if (c)          m_ovf = 1'b0;
        if (r && was_empty)  m_unf = 1'b1;
        else if (c)          m_unf = 1'b0;
        #1;
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
        check_all();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] seq;
        n_checks = 0;
        n_fail   = 0;
        winc = 0; rinc = 0; clr_err = 0; wdata = '0;
        rst  = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Fill with 0..31, then attempt a write while full and clear the error.
        for (int i = 0; i < c_DEPTH; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
        step(1'b1, 64'hDEAD, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Drain all 32 words, then one read too many.
        for (int i = 0; i < c_DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Hold occupancy at 16 with simultaneous traffic across pointer wrap.
        seq = 64'h1000;
        for (int i = 0; i < 16; i++) begin step(1'b1, seq, 1'b0, 1'b0); seq++; end
        for (int i = 0; i < 100; i++) begin step(1'b1, seq, 1'b1, 1'b0); seq++; end

        // Simultaneous read+write while full.
        while (m_q.size() < c_DEPTH) begin step(1'b1, seq, 1'b0, 1'b0); seq++; end
        step(1'b1, seq, 1'b1, 1'b0); seq++;
        step(1'b0, '0, 1'b0, 1'b1);

        // Simultaneous read+write while empty, then pop the FWFT head.
        while (m_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 64'hA5, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);

        // Error set and clear in the same cycle: the set must win.
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset mid-burst at occupancy 10.
        for (int i = 0; i < 10; i++) step(1'b1, rnd64(), 1'b0, 1'b0);
        winc = 1'b1; wdata = rnd64();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        winc = 1'b0;
        #2;
        rst = 1'b0;
        step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic with occasional error clears.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 55), rnd64(),
                 ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
